// File: rtl/block_lock_ctrl_if.sv
// block_lock_ctrl_if -- header stream in, lock status out.
//   in_encoded_header  [1:0] sync header of the current 66-bit block
//   in_encoded_valid         qualifies in_encoded_header
//   out_block_lock           registered lock status
//   out_slip                 one-cycle request for a one-bit gearbox slip
//   out_decoder_valid        in_encoded_valid delayed one cycle, gated by lock
//   out_hi_ber               high bit-error-rate flag
// master: header source (gearbox side); slave: the lock controller.
interface block_lock_ctrl_if;
    logic [1:0] in_encoded_header;
    logic       in_encoded_valid;
    logic       out_block_lock;
    logic       out_slip;
    logic       out_decoder_valid;
    logic       out_hi_ber;

    modport master (
        output in_encoded_header, in_encoded_valid,
        input  out_block_lock, out_slip, out_decoder_valid, out_hi_ber
    );

    modport slave (
        input  in_encoded_header, in_encoded_valid,
        output out_block_lock, out_slip, out_decoder_valid, out_hi_ber
    );
endinterface

// File: rtl/block_lock_ctrl.sv
// block_lock_ctrl -- 64b/66b block lock state machine.
// Hunts for LOCK_COUNT consecutive valid sync headers, requests a gearbox
// slip on any bad header while hunting, and drops lock when BAD_LIMIT bad
// headers land inside one 64-beat window while locked.
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  block_lock_ctrl_if.slave (header in, lock/slip/valid/hi-BER out)
// Optional feature: define BLOCK_LOCK_BER_MONITOR_EN to build the hi-BER
// monitor; otherwise out_hi_ber is tied low and no BER counters exist.
module block_lock_ctrl #(
    parameter int LOCK_COUNT = 64,
    parameter int BAD_LIMIT  = 16,
    parameter int SLIP_WAIT  = 4,
    parameter int BER_WINDOW = 3125
) (
    input  logic             clk,
    input  logic             rst,
    block_lock_ctrl_if.slave bus
);
    localparam int WIN_LEN = 64;
    localparam int HOLD_W  = (SLIP_WAIT < 2) ? 1 : $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        LOCKED    = 2'd1,
        SLIP_HOLD = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [6:0]        r_good_cnt, w_good_nxt, w_good_inc;
    logic [6:0]        r_win_cnt, w_win_nxt, w_win_inc;
    logic [4:0]        r_bad_cnt, w_bad_nxt, w_bad_cand;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt, w_hold_inc;
    logic              r_block_lock, r_slip, r_dec_valid;
    logic              w_slip_nxt;
    logic              w_hdr_ok;

    // 01 and 10 are the only legal sync headers.
    assign w_hdr_ok   = bus.in_encoded_header[1] ^ bus.in_encoded_header[0];
    assign w_good_inc = r_good_cnt + 7'd1;
    assign w_win_inc  = r_win_cnt + 7'd1;
    assign w_bad_cand = r_bad_cnt + {4'd0, ~w_hdr_ok};
    assign w_hold_inc = r_hold_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_win_nxt   = r_win_cnt;
        w_bad_nxt   = r_bad_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_slip_nxt  = 1'b0;
        if (bus.in_encoded_valid) begin
            case (r_state)
                HUNT: begin
                    if (w_hdr_ok) begin
                        if (w_good_inc == 7'(LOCK_COUNT)) begin
                            w_state_nxt = LOCKED;
                            w_good_nxt  = '0;
                            w_win_nxt   = '0;
                            w_bad_nxt   = '0;
                        end else begin
                            w_good_nxt = w_good_inc;
                        end
                    end else begin
                        w_slip_nxt  = 1'b1;
                        w_good_nxt  = '0;
                        w_hold_nxt  = '0;
                        w_state_nxt = SLIP_HOLD;
                    end
                end
                SLIP_HOLD: begin
                    // Headers are meaningless while the gearbox settles.
                    if (w_hold_inc == HOLD_W'(SLIP_WAIT)) begin
                        w_state_nxt = HUNT;
                        w_hold_nxt  = '0;
                        w_good_nxt  = '0;
                    end else begin
                        w_hold_nxt = w_hold_inc;
                    end
                end
                LOCKED: begin
                    // Bad-limit test first so a limit hit on the last window
                    // beat still drops lock instead of rolling the window.
                    if (w_bad_cand == 5'(BAD_LIMIT)) begin
                        w_slip_nxt  = 1'b1;
                        w_win_nxt   = '0;
                        w_bad_nxt   = '0;
                        w_hold_nxt  = '0;
                        w_state_nxt = SLIP_HOLD;
                    end else if (w_win_inc == 7'(WIN_LEN)) begin
                        w_win_nxt = '0;
                        w_bad_nxt = '0;
                    end else begin
                        w_win_nxt = w_win_inc;
                        w_bad_nxt = w_bad_cand;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= HUNT;
            r_good_cnt   <= '0;
            r_win_cnt    <= '0;
            r_bad_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_block_lock <= 1'b0;
            r_slip       <= 1'b0;
            r_dec_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_good_cnt   <= w_good_nxt;
            r_win_cnt    <= w_win_nxt;
            r_bad_cnt    <= w_bad_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_block_lock <= (w_state_nxt == LOCKED);
            r_slip       <= w_slip_nxt;
            // Gated by the lock already on the wire, not the one being computed.
            r_dec_valid  <= bus.in_encoded_valid & r_block_lock;
        end
    end

    assign bus.out_block_lock    = r_block_lock;
    assign bus.out_slip          = r_slip;
    assign bus.out_decoder_valid = r_dec_valid;

`ifdef BLOCK_LOCK_BER_MONITOR_EN
    localparam int BW = (BER_WINDOW < 2) ? 1 : $clog2(BER_WINDOW + 1);

    logic [BW-1:0] r_ber_beats, w_ber_beats_inc;
    logic [4:0]    r_ber_bad, w_ber_bad_nxt;
    logic          r_hi_ber;

    assign w_ber_beats_inc = r_ber_beats + BW'(1);

    // Bad-header count saturates at the hi-BER threshold of 16.
    always_comb begin
        w_ber_bad_nxt = r_ber_bad;
        if (!w_hdr_ok && (r_ber_bad != 5'd16))
            w_ber_bad_nxt = r_ber_bad + 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ber_beats <= '0;
            r_ber_bad   <= '0;
            r_hi_ber    <= 1'b0;
        end else if (bus.in_encoded_valid) begin
            if (w_ber_beats_inc == BW'(BER_WINDOW)) begin
                r_hi_ber    <= (w_ber_bad_nxt >= 5'd16);
                r_ber_beats <= '0;
                r_ber_bad   <= '0;
            end else begin
                r_ber_beats <= w_ber_beats_inc;
                r_ber_bad   <= w_ber_bad_nxt;
            end
        end
    end

    assign bus.out_hi_ber = r_hi_ber;
`else
    assign bus.out_hi_ber = 1'b0;
`endif
endmodule
